// File: rtl/rr_mux_feeder.sv
// rr_mux_feeder: two-source round-robin arbiter feeding a registered
// a/b/sel operand stage for a downstream 2:1 mux, with per-source
// saturating transfer counters for debug.
module rr_mux_feeder #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_sel,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t state;
  pri_t state_next;
  logic load_ok;
  logic grant_a;
  logic grant_b;

  // Priority state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRI_A;
    else        state <= state_next;
  end

  // Grant selection and next priority: the side just served loses the next tie
  always_comb begin
    load_ok    = !out_valid || out_ready;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = state;
    if (load_ok) begin
      if (a_valid && b_valid) begin
        grant_a = (state == PRI_A);
        grant_b = (state == PRI_B);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    if (grant_a)      state_next = PRI_B;
    else if (grant_b) state_next = PRI_A;
    a_ready = grant_a;
    b_ready = grant_b;
  end

  // Registered operand stage; the losing operand is captured only if valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sel   <= 1'b0;
    end else if (load_ok) begin
      out_valid <= grant_a || grant_b;
      if (grant_a) begin
        out_a   <= a_data;
        out_sel <= 1'b0;
        if (b_valid) out_b <= b_data;
      end else if (grant_b) begin
        out_b   <= b_data;
        out_sel <= 1'b1;
        if (a_valid) out_a <= a_data;
      end
    end
  end

  // Saturating per-source transfer counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_valid && a_ready && (cnt_a != '1)) cnt_a <= cnt_a + 1'b1;
      if (b_valid && b_ready && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_mux_feeder.sv
// Self-checking bench for rr_mux_feeder: a behavioural model predicts
// grants, pushes expected operands to a scoreboard queue, and compares
// them when the downstream consumes the output.
module tb_rr_mux_feeder;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             a_valid, b_valid, out_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, out_valid, out_sel;
  logic [WIDTH-1:0] out_a, out_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  logic             a_ready2, b_ready2, out_valid2, out_sel2;
  logic [WIDTH-1:0] out_a2, out_b2;
  logic [1:0]       cnt_a2, cnt_b2;

  rr_mux_feeder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_sel(out_sel),
    .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation
  rr_mux_feeder #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
    .out_valid(out_valid2), .out_a(out_a2), .out_b(out_b2), .out_sel(out_sel2),
    .out_ready(out_ready), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
  } exp_t;

  exp_t sb[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state
  logic             m_pri;
  logic             m_ov;
  logic [WIDTH-1:0] m_oa, m_ob;
  logic             m_os;
  int unsigned      m_ca, m_cb, m_ca2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pri = 1'b0; m_ov = 1'b0; m_oa = '0; m_ob = '0; m_os = 1'b0;
    m_ca = 0; m_cb = 0; m_ca2 = 0;
    sb.delete();
  endtask

  // One clock of stimulus; inputs applied just after a rising edge,
  // everything checked on the following falling edge.
  task automatic step(input logic av, input logic [WIDTH-1:0] ad,
                      input logic bv, input logic [WIDTH-1:0] bd,
                      input logic ordy);
    logic lok, ga, gb;
    exp_t e;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    @(negedge clk);
    lok = !m_ov || ordy;
    ga  = lok && av && (!bv || !m_pri);
    gb  = lok && bv && (!av || m_pri);
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    check("out_valid", out_valid, m_ov);
    check("cnt_a", cnt_a, m_ca);
    check("cnt_b", cnt_b, m_cb);
    check("cnt_a_sat", cnt_a2, m_ca2);
    if (m_ov && !ordy) begin
      check("hold_out_a", out_a, m_oa);
      check("hold_out_sel", out_sel, m_os);
    end
    if (m_ov && ordy) begin
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_a", out_a, e.a);
        check("out_b", out_b, e.b);
        check("out_sel", out_sel, e.sel);
      end
    end
    if (lok) begin
      if (ga) begin
        m_oa = ad; if (bv) m_ob = bd; m_os = 1'b0; m_pri = 1'b1;
        m_ca = (m_ca == 255) ? 255 : m_ca + 1;
        m_ca2 = (m_ca2 == 3) ? 3 : m_ca2 + 1;
      end else if (gb) begin
        m_ob = bd; if (av) m_oa = ad; m_os = 1'b1; m_pri = 1'b0;
        m_cb = (m_cb == 255) ? 255 : m_cb + 1;
      end
      if (ga || gb) begin
        e.a = m_oa; e.b = m_ob; e.sel = m_os;
        sb.push_back(e);
      end
      m_ov = ga || gb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // 1: idle after reset
    check("rst_out_a", out_a, 0);
    check("rst_out_sel", out_sel, 0);
    repeat (5) step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);

    // 2: only A valid
    step(1'b1, 3'b110, 1'b0, 3'b111, 1'b1);
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);

    // 3: both valid continuously, alternation from a fresh reset
    do_reset();
    repeat (6) step(1'b1, 3'b010, 1'b1, 3'b101, 1'b1);
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
    check("alt_cnt_a", cnt_a, 3);
    check("alt_cnt_b", cnt_b, 3);

    // 4: backpressure holding an A result, then release -> B wins
    do_reset();
    step(1'b1, 3'b110, 1'b0, 3'b000, 1'b1);
    repeat (4) step(1'b1, 3'b011, 1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b011, 1'b1, 3'b100, 1'b1);
    check("release_sel_b", out_sel, 1);
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);

    // 5: saturation on the narrow-counter instance
    do_reset();
    for (int unsigned i = 0; i < 5; i++) step(1'b1, WIDTH'(i), 1'b0, 3'b000, 1'b1);
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
    check("sat_final", cnt_a2, 3);

    // 6: asynchronous reset mid-stream
    do_reset();
    step(1'b1, 3'b001, 1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b001, 1'b1, 3'b010, 1'b1);
    #2;
    check("pre_async_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_sel", out_sel, 0);
    check("async_cnt_a", cnt_a, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 3'b101, 1'b1, 3'b011, 1'b1);
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
    check("post_rst_sel_a", out_sel, 0);
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b1);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
